alu_cells_sequencer: RTL and testbench

Control-side initiator for the ALU cell datapath.
- Accepts one command per start pulse and steps the datapath mux selects, ALU enable/op and result demux through the required element sequence.
- Writes ALU results back to the activation memory, or routes them to a parameter register.
- Sits between the top-level autoencoder FSM and the ALU cell datapath. It replaces hand-driven control vectors with a start/busy/done handshake.

---
 rtl/alu_cells_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_cells_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cells_sequencer.sv
// alu_cells_sequencer
//   Control-side initiator for the ALU cell datapath. One command is accepted
//   per start pulse in IDLE. The block then steps the mux selects, the ALU
//   enable/op and the result demux through the element sequence. Each ALU
//   result is either written back to the activation memory (ELEMWISE/SCALAR)
//   or routed through the demux to a parameter register (PIXEL).
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start                      command strobe, sampled only in IDLE
//   cmd_mode                   0=ELEMWISE 1=SCALAR 2=PIXEL 3=NOP
//   cmd_op                     ALU op for the whole command
//   cmd_param_sel, cmd_dest    parameter-mux select / PIXEL result destination
//   alu_result                 combinational ALU output from the datapath
//   busy, done, err            handshake; err is valid together with done
//   mux_1..4_control           datapath operand selects
//   enable_ALU, op_select      ALU control
//   demux_1_control            result destination (15 = none)
//   mem_wr_en/addr/data        activation-memory write port
module alu_cells_sequencer #(
  parameter int N_ELEM = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cmd_mode,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_param_sel,
  input  logic [3:0]        cmd_dest,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [4:0]        mux_1_control,
  output logic [4:0]        mux_2_control,
  output logic [1:0]        mux_3_control,
  output logic [3:0]        mux_4_control,
  output logic              enable_ALU,
  output logic [1:0]        op_select,
  output logic [3:0]        demux_1_control,
  output logic              mem_wr_en,
  output logic [3:0]        mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam int STEP_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  localparam logic [1:0] MODE_ELEM   = 2'd0;
  localparam logic [1:0] MODE_SCALAR = 2'd1;
  localparam logic [1:0] MODE_PIXEL  = 2'd2;
  localparam logic [1:0] MODE_NOP    = 2'd3;

  localparam logic [3:0] DEMUX_NONE  = 4'd15;
  localparam logic [3:0] MUX4_BANK2  = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [1:0]        mode_q;
  logic [1:0]        op_q;
  logic [3:0]        param_q;
  logic [3:0]        dest_q;

  logic [1:0]        sel_mode;
  logic [3:0]        sel_param;
  logic [3:0]        sel_dest;
  logic [STEP_W-1:0] iss_step;
  logic              last_step;
  logic              cmd_reject;

  logic [4:0]        iss_m1;
  logic [4:0]        iss_m2;
  logic [1:0]        iss_m3;
  logic [3:0]        iss_m4;
  logic [3:0]        iss_dmx;

  // Outputs are registered, so the controls for the next ISSUE cycle are
  // computed one cycle early. From IDLE they come straight from the cmd_*
  // inputs (the command register is loaded on the same edge) and target
  // step 0. From WRITE they come from the command register and step+1.
  always_comb begin
    sel_mode  = (state == IDLE) ? cmd_mode      : mode_q;
    sel_param = (state == IDLE) ? cmd_param_sel : param_q;
    sel_dest  = (state == IDLE) ? cmd_dest      : dest_q;
    iss_step  = (state == IDLE) ? '0 : step + STEP_W'(1);
    last_step = (step == STEP_W'(N_ELEM - 1));
  end

  // Illegal commands: NOP, parameter select 7 (the mux_2 path) or beyond 8
  // for the parameter-using modes, and a demux target above 7 for PIXEL.
  always_comb begin
    cmd_reject = 1'b0;
    if (cmd_mode == MODE_NOP)
      cmd_reject = 1'b1;
    if ((cmd_mode == MODE_SCALAR || cmd_mode == MODE_PIXEL) &&
        (cmd_param_sel == 4'd7 || cmd_param_sel > 4'd8))
      cmd_reject = 1'b1;
    if (cmd_mode == MODE_PIXEL && cmd_dest > 4'd7)
      cmd_reject = 1'b1;
  end

  // Operand and destination selects for one ISSUE cycle.
  always_comb begin
    iss_m1  = '0;
    iss_m2  = '0;
    iss_m3  = 2'd1;
    iss_m4  = '0;
    iss_dmx = DEMUX_NONE;
    case (sel_mode)
      MODE_ELEM: begin
        iss_m1 = 5'(iss_step);
        iss_m2 = 5'(N_ELEM) + 5'(iss_step);
        iss_m4 = MUX4_BANK2;
      end
      MODE_SCALAR: begin
        iss_m1 = 5'(iss_step);
        iss_m4 = sel_param;
      end
      MODE_PIXEL: begin
        iss_m3  = 2'd0;
        iss_m4  = sel_param;
        iss_dmx = sel_dest;
      end
      default: ;
    endcase
  end

  // Sequencer FSM. Every output is assigned on the edge entering the state
  // it belongs to; leaving ISSUE always restores the idle controls so the
  // demux can only point at a parameter register while the ALU is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      step            <= '0;
      mode_q          <= '0;
      op_q            <= '0;
      param_q         <= '0;
      dest_q          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      mux_1_control   <= '0;
      mux_2_control   <= '0;
      mux_3_control   <= '0;
      mux_4_control   <= '0;
      enable_ALU      <= 1'b0;
      op_select       <= '0;
      demux_1_control <= DEMUX_NONE;
      mem_wr_en       <= 1'b0;
      mem_wr_addr     <= '0;
      mem_wr_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            mode_q  <= cmd_mode;
            op_q    <= cmd_op;
            param_q <= cmd_param_sel;
            dest_q  <= cmd_dest;
            step    <= '0;
            if (cmd_reject) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state           <= ISSUE;
              busy            <= 1'b1;
              enable_ALU      <= 1'b1;
              op_select       <= cmd_op;
              mux_1_control   <= iss_m1;
              mux_2_control   <= iss_m2;
              mux_3_control   <= iss_m3;
              mux_4_control   <= iss_m4;
              demux_1_control <= iss_dmx;
            end
          end
        end

        ISSUE: begin
          enable_ALU      <= 1'b0;
          op_select       <= '0;
          mux_1_control   <= '0;
          mux_2_control   <= '0;
          mux_3_control   <= '0;
          mux_4_control   <= '0;
          demux_1_control <= DEMUX_NONE;
          if (mode_q == MODE_PIXEL) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b0;
          end else begin
            state       <= WRITE;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= 4'(step);
            mem_wr_data <= alu_result;
          end
        end

        WRITE: begin
          mem_wr_en <= 1'b0;
          if (last_step) begin
            step  <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b0;
          end else begin
            step            <= iss_step;
            state           <= ISSUE;
            enable_ALU      <= 1'b1;
            op_select       <= op_q;
            mux_1_control   <= iss_m1;
            mux_2_control   <= iss_m2;
            mux_3_control   <= iss_m3;
            mux_4_control   <= iss_m4;
            demux_1_control <= iss_dmx;
          end
        end

        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cells_sequencer.sv
// tb_alu_cells_sequencer
//   Scoreboard bench for alu_cells_sequencer. A small datapath model drives
//   alu_result from the DUT controls. Each command pushes its expected ISSUE,
//   WRITE and DONE events, tagged with the expected cycle, into a queue. A
//   negedge monitor pops and compares whenever the DUT shows enable_ALU,
//   mem_wr_en or done.
module tb_alu_cells_sequencer;

  localparam int N_ELEM = 9;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [1:0]        cmd_mode;
  logic [1:0]        cmd_op;
  logic [3:0]        cmd_param_sel;
  logic [3:0]        cmd_dest;
  logic [DATA_W-1:0] alu_result;
  logic              busy;
  logic              done;
  logic              err;
  logic [4:0]        mux_1_control;
  logic [4:0]        mux_2_control;
  logic [1:0]        mux_3_control;
  logic [3:0]        mux_4_control;
  logic              enable_ALU;
  logic [1:0]        op_select;
  logic [3:0]        demux_1_control;
  logic              mem_wr_en;
  logic [3:0]        mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  alu_cells_sequencer #(.N_ELEM(N_ELEM), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cmd_mode       (cmd_mode),
    .cmd_op         (cmd_op),
    .cmd_param_sel  (cmd_param_sel),
    .cmd_dest       (cmd_dest),
    .alu_result     (alu_result),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .mux_1_control  (mux_1_control),
    .mux_2_control  (mux_2_control),
    .mux_3_control  (mux_3_control),
    .mux_4_control  (mux_4_control),
    .enable_ALU     (enable_ALU),
    .op_select      (op_select),
    .demux_1_control(demux_1_control),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_data    (mem_wr_data)
  );

  // Event record: kind 0 = ISSUE, 1 = WRITE, 2 = DONE.
  typedef struct {
    int          kind;
    int          cyc;
    logic [4:0]  m1;
    logic [4:0]  m2;
    logic [1:0]  m3;
    logic [3:0]  m4;
    logic [3:0]  dmx;
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        err;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Datapath stand-in: bank1 (0..8) holds i+1, bank2 (9..17) holds 2,
  // parameter 0 is input_weight 1.0 in Q8.8.
  logic [15:0] mem_model [0:17];
  logic [15:0] param_model [0:6];
  localparam logic [15:0] INPUT_PIXEL  = 16'h0007;
  localparam logic [15:0] OUTPUT_PIXEL = 16'h0005;

  initial begin
    for (int i = 0; i < 9; i++) begin
      mem_model[i]     = 16'(i + 1);
      mem_model[i + 9] = 16'd2;
    end
    param_model[0] = 16'h0100;
    for (int i = 1; i < 7; i++) param_model[i] = 16'(16 * i);
  end

  function automatic logic [15:0] dp_eval(input logic [4:0] m1, input logic [4:0] m2,
                                          input logic [1:0] m3, input logic [3:0] m4,
                                          input logic [1:0] op);
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    a = (m3 == 2'd0) ? INPUT_PIXEL : ((m1 < 5'd18) ? mem_model[m1] : 16'h0);
    if (m4 == 4'd7)      b = (m2 < 5'd18) ? mem_model[m2] : 16'h0;
    else if (m4 == 4'd8) b = OUTPUT_PIXEL;
    else if (m4 < 4'd7)  b = param_model[m4[2:0]];
    else                 b = 16'h0;
    p = 32'(a) * 32'(b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return p[23:8];
      default: return a;
    endcase
  endfunction

  always_comb begin
    alu_result = '0;
    if (enable_ALU)
      alu_result = dp_eval(mux_1_control, mux_2_control, mux_3_control, mux_4_control, op_select);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " busy"},  32'(busy), 32'd0);
    check_output({tag, " done"},  32'(done), 32'd0);
    check_output({tag, " err"},   32'(err), 32'd0);
    check_output({tag, " en"},    32'(enable_ALU), 32'd0);
    check_output({tag, " wr_en"}, 32'(mem_wr_en), 32'd0);
    check_output({tag, " muxes"}, {10'd0, mux_1_control, mux_2_control, mux_3_control, mux_4_control, op_select}, 32'd0);
    check_output({tag, " demux"}, 32'(demux_1_control), 32'd15);
    check_output({tag, " wr_addr_data"}, {12'd0, mem_wr_addr, mem_wr_data}, 32'd0);
  endtask

  // Issue one command and queue the events it must produce.
  task automatic apply_stimulus(input logic [1:0] mode, input logic [1:0] op,
                                input logic [3:0] psel, input logic [3:0] dest,
                                input bit exp_err, output int base);
    exp_t e;
    @(negedge clk);
    base          = cyc;
    cmd_mode      = mode;
    cmd_op        = op;
    cmd_param_sel = psel;
    cmd_dest      = dest;
    start         = 1'b1;
    e = '{kind: 0, cyc: 0, m1: 0, m2: 0, m3: 0, m4: 0, dmx: 15, op: 0,
          addr: 0, data: 0, err: 0, busy: 1};
    if (exp_err) begin
      e.kind = 2; e.cyc = base + 1; e.err = 1'b1; e.busy = 1'b0;
      q.push_back(e);
    end else if (mode == 2'd2) begin
      e.kind = 0; e.cyc = base + 1; e.m3 = 2'd0; e.m4 = psel; e.dmx = dest; e.op = op;
      q.push_back(e);
      e.kind = 2; e.cyc = base + 2; e.busy = 1'b0; e.err = 1'b0;
      q.push_back(e);
    end else begin
      for (int i = 0; i < N_ELEM; i++) begin
        e.kind = 0; e.cyc = base + 2 * i + 1; e.op = op; e.m3 = 2'd1; e.dmx = 4'd15;
        e.m1 = 5'(i);
        e.m2 = (mode == 2'd0) ? 5'(9 + i) : 5'd0;
        e.m4 = (mode == 2'd0) ? 4'd7 : psel;
        e.data = dp_eval(e.m1, e.m2, e.m3, e.m4, op);
        e.busy = 1'b1;
        q.push_back(e);
        e.kind = 1; e.cyc = base + 2 * i + 2; e.addr = 4'(i);
        q.push_back(e);
      end
      e.kind = 2; e.cyc = base + 2 * N_ELEM + 1; e.busy = 1'b0; e.err = 1'b0;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for all queued events, then idle a few cycles so stray
  // events after the command are caught by the monitor.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout: %0d events outstanding, required 0", name, q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops one expected event per observed DUT event.
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if (rst_n) begin
      if (32'(enable_ALU) + 32'(mem_wr_en) + 32'(done) > 1)
        check_output("one event per cycle", 32'(enable_ALU) + 32'(mem_wr_en) + 32'(done), 32'd1);
      if (!enable_ALU)
        check_output("demux idle", 32'(demux_1_control), 32'd15);
      if (enable_ALU || mem_wr_en || done) begin
        kind = enable_ALU ? 0 : (mem_wr_en ? 1 : 2);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected event: got kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
          e = q.pop_front();
          check_output("event kind", 32'(kind), 32'(e.kind));
          check_output("event cycle", 32'(cyc), 32'(e.cyc));
          check_output("busy", 32'(busy), 32'(e.busy));
          if (kind == e.kind) begin
            if (kind == 0) begin
              check_output("mux_1", 32'(mux_1_control), 32'(e.m1));
              check_output("mux_2", 32'(mux_2_control), 32'(e.m2));
              check_output("mux_3", 32'(mux_3_control), 32'(e.m3));
              check_output("mux_4", 32'(mux_4_control), 32'(e.m4));
              check_output("demux", 32'(demux_1_control), 32'(e.dmx));
              check_output("op_select", 32'(op_select), 32'(e.op));
            end else if (kind == 1) begin
              check_output("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
              check_output("wr_data", 32'(mem_wr_data), 32'(e.data));
            end else begin
              check_output("err", 32'(err), 32'(e.err));
            end
          end
        end
      end
    end
  end

  initial begin
    int base;
    rst_n         = 1'b0;
    start         = 1'b0;
    cmd_mode      = '0;
    cmd_op        = '0;
    cmd_param_sel = '0;
    cmd_dest      = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] reset mid ELEMWISE at step 4");
    apply_stimulus(2'd0, 2'd0, 4'd0, 4'd0, 1'b0, base);
    while (cyc < base + 9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_values("after reset");

    $display("[TB] ELEMWISE add");
    apply_stimulus(2'd0, 2'd0, 4'd0, 4'd0, 1'b0, base);
    wait_idle("elemwise");

    $display("[TB] SCALAR multiply by input_weight");
    apply_stimulus(2'd1, 2'd2, 4'd0, 4'd0, 1'b0, base);
    wait_idle("scalar");

    $display("[TB] PIXEL to destination 2");
    apply_stimulus(2'd2, 2'd0, 4'd8, 4'd2, 1'b0, base);
    wait_idle("pixel");

    $display("[TB] rejected commands");
    apply_stimulus(2'd1, 2'd0, 4'd7, 4'd0, 1'b1, base);
    wait_idle("reject param 7");
    apply_stimulus(2'd3, 2'd0, 4'd0, 4'd0, 1'b1, base);
    wait_idle("reject nop");
    apply_stimulus(2'd1, 2'd0, 4'd9, 4'd0, 1'b1, base);
    wait_idle("reject param 9");
    apply_stimulus(2'd2, 2'd0, 4'd8, 4'd9, 1'b1, base);
    wait_idle("reject dest 9");

    $display("[TB] start while busy and in DONE is ignored");
    apply_stimulus(2'd0, 2'd1, 4'd0, 4'd0, 1'b0, base);
    @(negedge clk);
    cmd_mode = 2'd2; cmd_op = 2'd3; cmd_param_sel = 4'd8; cmd_dest = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < base + 19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy ignore");

    $display("[TB] start accepted in IDLE");
    apply_stimulus(2'd2, 2'd1, 4'd3, 4'd5, 1'b0, base);
    wait_idle("idle accept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
